// File: rtl/phy_tx_serial_pkg.sv
// rtl/phy_tx_serial_pkg.sv - lane protocol constants and types shared by phy_tx_serial and phy_rx
package phy_tx_serial_pkg;

  localparam logic [7:0] COM_CHAR_DEFAULT   = 8'hBC;
  localparam int         SYNC_SLOTS_DEFAULT = 2;
  localparam int         SLOT_BITS          = 16;

  // Byte indices within a word (3 = [31:24]); each lane sends its first byte then its second.
  localparam int LANE0_FIRST_BYTE  = 3;
  localparam int LANE0_SECOND_BYTE = 1;
  localparam int LANE1_FIRST_BYTE  = 2;
  localparam int LANE1_SECOND_BYTE = 0;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_DATA = 2'd2
  } phy_state_t;

  function automatic logic [15:0] lane_pair(input logic [31:0] word, input int first, input int second);
    return {word[first*8 +: 8], word[second*8 +: 8]};
  endfunction

endpackage

// File: rtl/phy_tx_serial_lane_serializer.sv
// rtl/phy_tx_serial_lane_serializer.sv - 16-bit load/shift register driving one serial lane, MSB first
module phy_tx_serial_lane_serializer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_data,
  output logic        msb
);

  logic [15:0] shreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= 16'h0000;
    end else if (load) begin
      shreg <= load_data;
    end else begin
      shreg <= {shreg[14:0], 1'b0};
    end
  end

  assign msb = shreg[15];

endmodule

// File: rtl/phy_tx_serial.sv
// rtl/phy_tx_serial.sv - two-lane serial transmitter; stripes 32-bit words over two lanes, COM fills idle slots
// Data bytes equal to COM_CHAR are sent as-is (no escaping), so a receiver may mistake them for sync.
module phy_tx_serial
  import phy_tx_serial_pkg::*;
#(
  parameter logic [7:0] COM_CHAR   = COM_CHAR_DEFAULT,
  parameter int         SYNC_SLOTS = SYNC_SLOTS_DEFAULT
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic [31:0] data_in_phytx,
  input  logic        valid_in_phytx,
  output logic        ready_phytx,
  output logic        data_out0,
  output logic        data_out1,
  output logic        data_slot
);

  localparam int SYNC_W = (SYNC_SLOTS > 1) ? $clog2(SYNC_SLOTS) : 1;

  phy_state_t        state;
  logic [3:0]        bit_cnt;
  logic [SYNC_W-1:0] sync_cnt;
  logic              boundary;
  logic              take_word;
  logic [15:0]       load0;
  logic [15:0]       load1;

  assign boundary    = (bit_cnt == 4'(SLOT_BITS - 1));
  assign ready_phytx = boundary && (state != ST_SYNC) && !reset;
  assign take_word   = ready_phytx && valid_in_phytx;

  assign load0 = take_word ? lane_pair(data_in_phytx, LANE0_FIRST_BYTE, LANE0_SECOND_BYTE)
                           : {COM_CHAR, COM_CHAR};
  assign load1 = take_word ? lane_pair(data_in_phytx, LANE1_FIRST_BYTE, LANE1_SECOND_BYTE)
                           : {COM_CHAR, COM_CHAR};

  // bit_cnt resets to the boundary value so the first edge after release loads a COM slot.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      bit_cnt   <= 4'(SLOT_BITS - 1);
      state     <= ST_SYNC;
      sync_cnt  <= '0;
      data_slot <= 1'b0;
    end else if (boundary) begin
      bit_cnt <= 4'd0;
      case (state)
        ST_SYNC: begin
          data_slot <= 1'b0;
          if (sync_cnt == SYNC_W'(SYNC_SLOTS - 1)) begin
            state <= ST_IDLE;
          end else begin
            sync_cnt <= sync_cnt + 1'b1;
          end
        end
        default: begin
          data_slot <= take_word;
          state     <= take_word ? ST_DATA : ST_IDLE;
        end
      endcase
    end else begin
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  phy_tx_serial_lane_serializer u_lane0 (
    .clk       (clk_32f),
    .reset     (reset),
    .load      (boundary),
    .load_data (load0),
    .msb       (data_out0)
  );

  phy_tx_serial_lane_serializer u_lane1 (
    .clk       (clk_32f),
    .reset     (reset),
    .load      (boundary),
    .load_data (load1),
    .msb       (data_out1)
  );

endmodule

// File: tb/tb_phy_tx_serial.sv
// tb/tb_phy_tx_serial.sv - self-checking bench for phy_tx_serial against a slot-level lane model
module tb_phy_tx_serial;

  localparam logic [7:0] COM = 8'hBC;
  localparam int SYNC_EDGES = 32;

  logic        clk_32f = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_in_phytx = '0;
  logic        valid_in_phytx = 1'b0;
  logic        ready_phytx;
  logic        data_out0;
  logic        data_out1;
  logic        data_slot;

  int errors = 0;
  int checks = 0;

  // Model: n is the index of the next edge counted from reset release; queues hold expected
  // {lane0, lane1, data_slot} for each upcoming cycle.
  int n = 0;
  bit q0[$];
  bit q1[$];
  bit qs[$];

  always #5 clk_32f = ~clk_32f;

  phy_tx_serial dut (
    .clk_32f        (clk_32f),
    .reset          (reset),
    .data_in_phytx  (data_in_phytx),
    .valid_in_phytx (valid_in_phytx),
    .ready_phytx    (ready_phytx),
    .data_out0      (data_out0),
    .data_out1      (data_out1),
    .data_slot      (data_slot)
  );

  task automatic run_edge(input logic rst, input logic vld, input logic [31:0] w,
                          output logic obs_rdy, output logic exp_rdy,
                          output logic [2:0] obs, output logic [2:0] exp);
    logic [31:0] slot;
    logic [15:0] l0, l1;
    bit is_data;
    reset = rst;
    valid_in_phytx = vld;
    data_in_phytx = w;
    #1;
    obs_rdy = ready_phytx;
    exp_rdy = !rst && (n >= SYNC_EDGES) && (n % 16 == 0);
    @(posedge clk_32f);
    #1;
    if (rst) begin
      q0.delete();
      q1.delete();
      qs.delete();
      n = 0;
      exp = 3'b000;
    end else begin
      if (n % 16 == 0) begin
        is_data = exp_rdy && vld;
        slot = is_data ? w : {COM, COM, COM, COM};
        l0 = {slot[31:24], slot[15:8]};
        l1 = {slot[23:16], slot[7:0]};
        for (int k = 15; k >= 0; k--) begin
          q0.push_back(l0[k]);
          q1.push_back(l1[k]);
          qs.push_back(is_data);
        end
      end
      exp = {q0.pop_front(), q1.pop_front(), qs.pop_front()};
      n++;
    end
    obs = {data_out0, data_out1, data_slot};
  endtask

  task automatic test_reset();
    logic orr, err;
    logic [2:0] o, e;
    int first_rdy = -1;
    int pulses = 0;
    logic [7:0] first_byte = '0;
    for (int i = 0; i < 5; i++) begin
      run_edge(1'b1, 1'b0, 32'h0, orr, err, o, e);
      checks++;
      if (o !== 3'b000 || orr !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: got out=%b ready=%b, required out=000 ready=0", o, orr);
      end
    end
    for (int i = 0; i < 80; i++) begin
      run_edge(1'b0, 1'b0, 32'h0, orr, err, o, e);
      if (orr && first_rdy < 0) first_rdy = i;
      if (orr) pulses++;
      if (i < 8) first_byte = {first_byte[6:0], o[2]};
      checks++;
      if (o !== e || orr !== err) begin
        errors++;
        $display("FAIL sync_stream edge %0d: got out=%b ready=%b, required out=%b ready=%b", i, o, orr, e, err);
      end
    end
    checks++;
    if (first_rdy !== 32) begin
      errors++;
      $display("FAIL first_ready_edge: got %0d required 32", first_rdy);
    end
    checks++;
    if (pulses !== 3) begin
      errors++;
      $display("FAIL ready_pulse_count: got %0d required 3", pulses);
    end
    checks++;
    if (first_byte !== COM) begin
      errors++;
      $display("FAIL first_com_byte: got %h required %h", first_byte, COM);
    end
  endtask

  task automatic test_single_word();
    logic orr, err;
    logic [2:0] o, e;
    logic vld = 1'b1;
    bit accepted = 0;
    int after = 0;
    int slot_hi = 0;
    logic [15:0] lane0 = '0, lane1 = '0;
    for (int i = 0; i < 80; i++) begin
      run_edge(1'b0, vld, 32'hA1B2C3D4, orr, err, o, e);
      if (accepted) begin
        if (after < 16) begin
          lane0 = {lane0[14:0], o[2]};
          lane1 = {lane1[14:0], o[1]};
        end
        if (o[0]) slot_hi++;
        after++;
      end
      if (orr && vld) begin
        accepted = 1;
        vld = 1'b0;
        lane0 = {lane0[14:0], o[2]};
        lane1 = {lane1[14:0], o[1]};
        after = 1;
        if (o[0]) slot_hi++;
      end
      checks++;
      if (o !== e || orr !== err) begin
        errors++;
        $display("FAIL single_word edge %0d: got out=%b ready=%b, required out=%b ready=%b", i, o, orr, e, err);
      end
    end
    checks++;
    if (!accepted) begin
      errors++;
      $display("FAIL single_word_accept: got no handshake, required one");
    end
    checks++;
    if (lane0 !== 16'hA1C3 || lane1 !== 16'hB2D4) begin
      errors++;
      $display("FAIL single_word_bytes: got %h/%h required a1c3/b2d4", lane0, lane1);
    end
    checks++;
    if (slot_hi !== 16) begin
      errors++;
      $display("FAIL single_word_slot_len: got %0d required 16", slot_hi);
    end
  endtask

  task automatic test_back_to_back();
    logic orr, err;
    logic [2:0] o, e;
    logic [31:0] words [3] = '{32'hFFFF0000, 32'h12345678, 32'h00000000};
    int idx = 0;
    int run = 0;
    int max_run = 0;
    for (int i = 0; i < 100; i++) begin
      run_edge(1'b0, idx < 3, (idx < 3) ? words[idx] : 32'h0, orr, err, o, e);
      if (orr && idx < 3) idx++;
      run = o[0] ? run + 1 : 0;
      if (run > max_run) max_run = run;
      checks++;
      if (o !== e || orr !== err) begin
        errors++;
        $display("FAIL back_to_back edge %0d: got out=%b ready=%b, required out=%b ready=%b", i, o, orr, e, err);
      end
    end
    checks++;
    if (idx !== 3) begin
      errors++;
      $display("FAIL back_to_back_count: got %0d words required 3", idx);
    end
    checks++;
    if (max_run !== 48) begin
      errors++;
      $display("FAIL back_to_back_slot_run: got %0d required 48", max_run);
    end
  endtask

  task automatic test_valid_during_sync();
    logic orr, err;
    logic [2:0] o, e;
    logic vld = 1'b1;
    logic [31:0] com_bits = '0;
    int early_rdy = 0;
    for (int i = 0; i < 3; i++) run_edge(1'b1, 1'b1, 32'hDEADBEEF, orr, err, o, e);
    for (int i = 0; i < 64; i++) begin
      run_edge(1'b0, vld, 32'hDEADBEEF, orr, err, o, e);
      if (i < 32) begin
        com_bits = {com_bits[30:0], o[2]};
        if (orr) early_rdy++;
      end
      if (orr && vld) vld = 1'b0;
      checks++;
      if (o !== e || orr !== err) begin
        errors++;
        $display("FAIL sync_valid edge %0d: got out=%b ready=%b, required out=%b ready=%b", i, o, orr, e, err);
      end
    end
    checks++;
    if (early_rdy !== 0) begin
      errors++;
      $display("FAIL sync_ready_low: got %0d pulses required 0", early_rdy);
    end
    checks++;
    if (com_bits !== {COM, COM, COM, COM}) begin
      errors++;
      $display("FAIL sync_com_bytes: got %h required bcbcbcbc", com_bits);
    end
  endtask

  task automatic test_mid_reset();
    logic orr, err;
    logic [2:0] o, e;
    logic vld = 1'b1;
    int after = -1;
    int first_rdy = -1;
    int slot_seen = 0;
    logic [31:0] com_bits = '0;
    for (int i = 0; i < 40 && after < 6; i++) begin
      run_edge(1'b0, vld, 32'h5A5A0F0F, orr, err, o, e);
      if (after >= 0) after++;
      if (orr && vld) begin
        vld = 1'b0;
        after = 0;
      end
      checks++;
      if (o !== e || orr !== err) begin
        errors++;
        $display("FAIL mid_reset_pre edge %0d: got out=%b ready=%b, required out=%b ready=%b", i, o, orr, e, err);
      end
    end
    run_edge(1'b1, 1'b0, 32'h0, orr, err, o, e);
    checks++;
    if (o !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset_zero: got %b required 000", o);
    end
    run_edge(1'b1, 1'b0, 32'h0, orr, err, o, e);
    for (int i = 0; i < 50; i++) begin
      run_edge(1'b0, 1'b0, 32'h0, orr, err, o, e);
      if (orr && first_rdy < 0) first_rdy = i;
      if (o[0]) slot_seen++;
      if (i < 32) com_bits = {com_bits[30:0], o[1]};
      checks++;
      if (o !== e || orr !== err) begin
        errors++;
        $display("FAIL mid_reset_post edge %0d: got out=%b ready=%b, required out=%b ready=%b", i, o, orr, e, err);
      end
    end
    checks++;
    if (first_rdy !== 32 || slot_seen !== 0 || com_bits !== {COM, COM, COM, COM}) begin
      errors++;
      $display("FAIL mid_reset_resync: got ready_edge=%0d slot_cycles=%0d lane1=%h required 32/0/bcbcbcbc",
               first_rdy, slot_seen, com_bits);
    end
  endtask

  task automatic test_random();
    logic orr, err;
    logic [2:0] o, e;
    logic vld = 1'b0;
    logic [31:0] w = '0;
    logic rst;
    for (int i = 0; i < 1500; i++) begin
      if (!vld && $urandom_range(0, 3) == 0) begin
        vld = 1'b1;
        w = $urandom;
      end
      rst = ($urandom_range(0, 199) == 0);
      run_edge(rst, vld, w, orr, err, o, e);
      if (orr && vld) vld = 1'b0;
      checks++;
      if (o !== e || orr !== err) begin
        errors++;
        $display("FAIL random edge %0d: got out=%b ready=%b, required out=%b ready=%b", i, o, orr, e, err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_valid_during_sync();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
